// File: rtl/id_stage_if.sv
// Bundle between fetch, write-back, execute and the decode stage.
// The master side feeds fetch/write-back data and observes the ID/EX outputs.
interface id_stage_if #(
  parameter int XLEN = 19
);
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            flush;
  logic            wb_we;
  logic [2:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall_out;
  logic            illegal_instr;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_alu_op;
  logic [2:0]      ex_rs1;
  logic [2:0]      ex_rs2;
  logic [2:0]      ex_rd;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;

  modport master (
    output if_pc, if_instr, flush, wb_we, wb_rd, wb_data,
    input  stall_out, illegal_instr, ex_valid, ex_pc, ex_alu_op,
           ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump
  );

  modport slave (
    input  if_pc, if_instr, flush, wb_we, wb_rd, wb_data,
    output stall_out, illegal_instr, ex_valid, ex_pc, ex_alu_op,
           ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decoder, 8x19 register file with write bypass,
// load-use hazard detection and a registered ID/EX bundle.
module id_stage #(
  parameter int              XLEN      = 19,
  parameter int              NREG      = 8,
  parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

  logic [4:0]      opcode;
  logic [2:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm;

  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic uses_rs1, uses_rs2, dec_illegal;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic stall, bubble;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [4:0]      ex_alu_op_q, ex_alu_op_d;
  logic [2:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d, ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic            ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
  logic            ex_mem_write_q, ex_mem_write_d, ex_branch_q, ex_branch_d;
  logic            ex_jump_q, ex_jump_d;
  logic            illegal_q, illegal_d;

  assign opcode = ifid_instr_q[18:14];
  assign rd     = ifid_instr_q[13:11];
  assign rs1    = ifid_instr_q[10:8];
  assign rs2    = ifid_instr_q[7:5];
  assign imm    = {{(XLEN-8){ifid_instr_q[7]}}, ifid_instr_q[7:0]};

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode[4:3])
      2'b00: begin dec_reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      2'b01: begin dec_reg_write = 1'b1; uses_rs1 = 1'b1; end
      default: begin
        case (opcode)
          5'h10: begin dec_mem_read = 1'b1; dec_reg_write = 1'b1; uses_rs1 = 1'b1; end
          5'h11: begin dec_mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
          5'h12, 5'h13: begin dec_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
          5'h14: dec_jump = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
    if (rd == '0) dec_reg_write = 1'b0;
  end

  // Reads see a same-cycle write-back so no extra WB->ID forwarding is needed
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (bus.wb_we && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1];
    if (rs2 != '0) rs2_val = (bus.wb_we && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2];
  end

  assign stall = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & ifid_valid_q &
                 ((uses_rs1 & (rs1 == ex_rd_q)) | (uses_rs2 & (rs2 == ex_rd_q)));
  assign bubble = ~ifid_valid_q | stall | dec_illegal | bus.flush;

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (bus.flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = bus.if_pc;
      ifid_instr_d = bus.if_instr;
    end

    ex_valid_d     = ~bubble;
    ex_pc_d        = ifid_pc_q;
    ex_alu_op_d    = opcode;
    ex_rs1_d       = rs1;
    ex_rs2_d       = rs2;
    ex_rd_d        = rd;
    ex_rs1_val_d   = rs1_val;
    ex_rs2_val_d   = rs2_val;
    ex_imm_d       = imm;
    ex_reg_write_d = dec_reg_write & ~bubble;
    ex_mem_read_d  = dec_mem_read  & ~bubble;
    ex_mem_write_d = dec_mem_write & ~bubble;
    ex_branch_d    = dec_branch    & ~bubble;
    ex_jump_d      = dec_jump      & ~bubble;

    illegal_d = ifid_valid_q & dec_illegal & ~bus.flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q   <= 1'b0;
      ifid_pc_q      <= '0;
      ifid_instr_q   <= NOP_INSTR;
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_alu_op_q    <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_rs1_val_q   <= '0;
      ex_rs2_val_q   <= '0;
      ex_imm_q       <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_jump_q      <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      ifid_valid_q   <= ifid_valid_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_val_q   <= ex_rs1_val_d;
      ex_rs2_val_q   <= ex_rs2_val_d;
      ex_imm_q       <= ex_imm_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_branch_q    <= ex_branch_d;
      ex_jump_q      <= ex_jump_d;
      illegal_q      <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.wb_we && bus.wb_rd != '0) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.stall_out     = stall;
  assign bus.illegal_instr = illegal_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_alu_op     = ex_alu_op_q;
  assign bus.ex_rs1        = ex_rs1_q;
  assign bus.ex_rs2        = ex_rs2_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rs1_val    = ex_rs1_val_q;
  assign bus.ex_rs2_val    = ex_rs2_val_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_branch     = ex_branch_q;
  assign bus.ex_jump       = ex_jump_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes expected ID/EX bundles into a queue,
// a negedge monitor pops one for every valid ID/EX output and compares it.
module tb_id_stage;
  localparam logic [4:0] RW = 5'b10000, MR = 5'b01000, MW = 5'b00100,
                         BR = 5'b00010, JP = 5'b00001;

  typedef struct {
    logic [18:0] pc;
    logic [4:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [18:0] v1, v2, imm;
    logic [4:0]  ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   ill_seen = 0;
  exp_t q[$];

  id_stage_if #(.XLEN(19)) bus ();

  id_stage #(.XLEN(19), .NREG(8), .NOP_INSTR(19'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [4:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  function automatic exp_t mk(input logic [18:0] pc, input logic [18:0] instr,
                              input logic [18:0] v1, input logic [18:0] v2,
                              input logic [4:0] ctrl);
    exp_t e;
    e.pc   = pc;
    e.op   = instr[18:14];
    e.rd   = instr[13:11];
    e.rs1  = instr[10:8];
    e.rs2  = instr[7:5];
    e.imm  = {{11{instr[7]}}, instr[7:0]};
    e.v1   = v1;
    e.v2   = v2;
    e.ctrl = ctrl;
    return e;
  endfunction

  task automatic drop(input logic [18:0] pc, input logic [18:0] instr, input logic fl);
    bus.if_pc    = pc;
    bus.if_instr = instr;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [18:0] pc, input logic [18:0] instr,
                    input logic [18:0] v1, input logic [18:0] v2, input logic [4:0] ctrl);
    q.push_back(mk(pc, instr, v1, v2, ctrl));
    drop(pc, instr, 1'b0);
  endtask

  task automatic nop();
    go(19'd0, 19'd0, 19'd0, 19'd0, 5'd0);
  endtask

  task automatic wb(input logic we, input logic [2:0] rd, input logic [18:0] d);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(bus.ex_valid), 0);
    chk({tag, "_stall"}, 32'(bus.stall_out), 0);
    chk({tag, "_illegal"}, 32'(bus.illegal_instr), 0);
    chk({tag, "_ex_pc"}, 32'(bus.ex_pc), 0);
    chk({tag, "_ex_vals"}, 32'({bus.ex_rs1_val, bus.ex_rd}), 0);
    chk({tag, "_ex_imm"}, 32'(bus.ex_imm), 0);
    chk({tag, "_ex_ctrl"}, 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                bus.ex_branch, bus.ex_jump}), 0);
  endtask

  // Monitor: every valid ID/EX bundle must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.illegal_instr) ill_seen++;
      if (!rst && bus.ex_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ex_unexpected: got valid pc %0h expected no instruction", bus.ex_pc);
        end else begin
          e = q.pop_front();
          chk("ex_pc", 32'(bus.ex_pc), 32'(e.pc));
          chk("ex_op_rd", 32'({bus.ex_alu_op, bus.ex_rd}), 32'({e.op, e.rd}));
          chk("ex_rs_idx", 32'({bus.ex_rs1, bus.ex_rs2}), 32'({e.rs1, e.rs2}));
          chk("ex_rs1_val", 32'(bus.ex_rs1_val), 32'(e.v1));
          chk("ex_rs2_val", 32'(bus.ex_rs2_val), 32'(e.v2));
          chk("ex_imm", 32'(bus.ex_imm), 32'(e.imm));
          chk("ex_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                              bus.ex_branch, bus.ex_jump}), 32'(e.ctrl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_pc = '0; bus.if_instr = '0; bus.flush = 1'b0;
    wb(1'b0, 3'd0, 19'd0);
    @(posedge clk);
    #3;
    chk_zero("reset");
    #4;
    rst = 1'b0;

    // ALU-R basic issue
    go(19'd5, 19'h00A48, 19'd0, 19'd0, RW);
    // write-back bypass and r0 write ignored
    go(19'd6, enc(5'h00, 3'd4, 3'd2, 3'd0, 5'd0), 19'h01234, 19'd0, RW);
    wb(1'b1, 3'd2, 19'h01234);
    go(19'd7, enc(5'h00, 3'd5, 3'd2, 3'd0, 5'd0), 19'h01234, 19'd0, RW);
    wb(1'b1, 3'd0, 19'h7FFFF);
    go(19'd8, enc(5'h10, 3'd3, 3'd2, 3'd0, 5'd5), 19'h01234, 19'd0, RW | MR);
    wb(1'b0, 3'd0, 19'd0);
    // load-use: one stall cycle, one bubble, then the held word issues
    go(19'd9, enc(5'h00, 3'd6, 3'd1, 3'd3, 5'd0), 19'd0, 19'h00ABC, RW);
    chk("lu_stall_on", 32'(bus.stall_out), 1);
    wb(1'b1, 3'd3, 19'h00ABC);
    drop(19'd10, 19'd0, 1'b0);
    wb(1'b0, 3'd0, 19'd0);
    chk("lu_stall_off", 32'(bus.stall_out), 0);
    chk("lu_bubble", 32'(bus.ex_valid), 0);
    // load to r0 never stalls
    go(19'd10, enc(5'h10, 3'd0, 3'd2, 3'd0, 5'd5), 19'h01234, 19'd0, MR);
    go(19'd11, enc(5'h00, 3'd6, 3'd0, 3'd0, 5'd0), 19'd0, 19'd0, RW);
    chk("rd0_no_stall", 32'(bus.stall_out), 0);
    // other classes, negative immediate
    go(19'd12, enc(5'h08, 3'd7, 3'd3, 3'd7, 5'h10), 19'h00ABC, 19'd0, RW);
    go(19'd13, enc(5'h11, 3'd0, 3'd2, 3'd3, 5'd0), 19'h01234, 19'h00ABC, MW);
    go(19'd14, enc(5'h12, 3'd0, 3'd3, 3'd2, 5'd0), 19'h00ABC, 19'h01234, BR);
    go(19'd15, enc(5'h14, 3'd0, 3'd0, 3'd0, 5'h1F), 19'd0, 19'd0, JP);
    // illegal opcode pulse
    drop(19'd9, enc(5'h1F, 3'd0, 3'd0, 3'd0, 5'd0), 1'b0);
    nop();
    chk("ill_pulse", 32'(bus.illegal_instr), 1);
    chk("ill_bubble", 32'(bus.ex_valid), 0);
    nop();
    chk("ill_deassert", 32'(bus.illegal_instr), 0);
    // illegal squashed by flush
    drop(19'd9, enc(5'h1F, 3'd0, 3'd0, 3'd0, 5'd0), 1'b0);
    drop(19'd0, 19'd0, 1'b1);
    chk("ill_flush_nopulse", 32'(bus.illegal_instr), 0);
    chk("ill_flush_bubble", 32'(bus.ex_valid), 0);
    // flush during a stall
    go(19'd20, enc(5'h10, 3'd3, 3'd2, 3'd0, 5'd5), 19'h01234, 19'd0, RW | MR);
    drop(19'd21, enc(5'h00, 3'd6, 3'd1, 3'd3, 5'd0), 1'b0);
    chk("fs_stall_on", 32'(bus.stall_out), 1);
    drop(19'd22, 19'd0, 1'b1);
    chk("fs_stall_off", 32'(bus.stall_out), 0);
    chk("fs_ex_bubble", 32'(bus.ex_valid), 0);
    nop();
    chk("fs_ifid_cleared", 32'(bus.ex_valid), 0);
    // asynchronous reset mid-stall
    go(19'd30, enc(5'h10, 3'd3, 3'd2, 3'd0, 5'd5), 19'h01234, 19'd0, RW | MR);
    drop(19'd31, enc(5'h00, 3'd6, 3'd1, 3'd3, 5'd0), 1'b0);
    chk("ar_stall_on", 32'(bus.stall_out), 1);
    #6;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    #9;
    rst = 1'b0;
    go(19'd40, enc(5'h00, 3'd1, 3'd2, 3'd3, 5'd0), 19'd0, 19'd0, RW);
    nop();
    nop();
    drop(19'd0, 19'd0, 1'b0);
    bus.flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_idle", 32'(bus.ex_valid), 0);
    chk("sb_drained", 32'(q.size()), 0);
    chk("ill_pulses", 32'(ill_seen), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage in the 19-bit pipelined core.
- Latches the fetched pc/instruction into an internal IF/ID register, decodes it, and reads an 8x19 register file with a write-back port.
- Detects load-use hazards, stalling fetch and inserting a bubble.
- Drives a registered ID/EX bundle to execute and flags illegal opcodes to the exception logic.

Parameters:
- XLEN, 19, datapath/instruction/pc width
- NREG, 8, register count; r0 reads zero
- NOP_INSTR, 19'h0, instruction injected on flush/reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_pc  in  19  pc of fetched instruction
- if_instr  in  19  fetched instruction
- flush  in  1  branch taken or exception; squash IF/ID and ID/EX
- wb_we  in  1  write-back enable
- wb_rd  in  3  write-back register
- wb_data  in  19  write-back data
- stall_out  out  1  load-use hazard; drives fetch stall
- illegal_instr  out  1  one-cycle pulse: valid IF/ID word has undefined opcode
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  19  pc of ID/EX instruction
- ex_alu_op  out  5  opcode passthrough
- ex_rs1, ex_rs2, ex_rd  out  3 each  register indices (for forwarding)
- ex_rs1_val, ex_rs2_val  out  19 each  operand values
- ex_imm  out  19  sign-extended instr[7:0]
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  control

Behaviour:
- Encoding: opcode=[18:14], rd=[13:11], rs1=[10:8], rs2=[7:5], imm=[7:0], sign-extended from bit 7.
- Opcode classes:
  - 0x00-0x07 ALU-R: reg_write; uses rs1 and rs2.
  - 0x08-0x0F ALU-I: reg_write; uses rs1.
  - 0x10 LOAD: mem_read, reg_write; uses rs1.
  - 0x11 STORE: mem_write; uses rs1 and rs2.
  - 0x12 BEQ, 0x13 BNE: branch; uses rs1 and rs2.
  - 0x14 JMP: jump; no source registers.
  - 0x15-0x1F: illegal.
- reg_write is forced 0 when rd=0.
- IF/ID register (valid, pc, instr):
  - Loads every edge unless stalled.
  - On flush: valid<=0, instr<=NOP_INSTR.
  - On stall without flush: holds.
- ID/EX register:
  - Loads the decode of IF/ID each edge.
  - Bubble (ex_valid=0, all control outputs 0) when IF/ID invalid, stall_out=1, illegal opcode, or flush.
  - Data fields in a bubble are don't-care but must hold no X after reset.
- Priority: flush > stall > normal.
- Hazard, combinational: stall_out=1 iff ex_valid & ex_mem_read & ex_rd!=0 & IF/ID valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)). A one-cycle stall is sufficient.
- illegal_instr: registered; asserted the edge after an illegal word sits valid in IF/ID with no flush. Deasserts next cycle unless another illegal word arrives.
- Register file:
  - Synchronous write on wb_we & wb_rd!=0.
  - Combinational read with same-cycle write-bypass: if wb_we & wb_rd==rs & rs!=0, read wb_data.
  - r0 always reads 0; writes to r0 are ignored.
- Latency: word present at if_instr before edge N is in IF/ID after N and on ex_* after N+1.
- Reset (asynchronous, any time including mid-stall):
  - IF/ID valid=0, instr=NOP_INSTR, pc=0.
  - All ex_* = 0.
  - All registers = 0.
  - illegal_instr=0; stall_out=0 combinationally.
- An assertion of flush during a stall clears both registers; stall_out drops once ID/EX is a bubble.

Test Plan:
1. Reset then ALU-R word 19'h00A48 (op0 rd1 rs1 2 rs2 2) at pc 5 -> two edges later: ex_valid=1, ex_pc=5, ex_rd=1, ex_reg_write=1.
2. WB writes r2=19'h1234 in the same cycle IF/ID reads r2 -> ex_rs1_val=19'h1234 (bypass). A write to r0 -> r0 reads 0.
3. LOAD r3 followed by ALU-R using rs2=r3 -> stall_out=1 for exactly one cycle, one bubble (ex_valid=0), then the ALU instruction issues with IF/ID held. The same sequence with rd=0 -> no stall.
4. Opcode 0x1F at pc 9 -> illegal_instr one-cycle pulse, ex_valid=0. With flush in the same cycle -> no pulse.
5. flush asserted while stall_out=1 -> next edge: IF/ID and ID/EX invalid, stall_out=0.
6. rst asserted asynchronously mid-stream, away from any clock edge -> outputs zero immediately, registers cleared, and the first instruction after release decodes correctly.
